countdown_timer_bank: RTL and testbench
=======================================

COUNTDOWN_TIMER_BANK -- requirements
Module: countdown_timer_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent countdown channels, legal range 1..16.
REQ-002 SHALL have parameter MAX_TENS_MIN, default 9: largest legal tens-of-minutes digit.
REQ-003 SHALL have parameter ALARM_TICKS, default 10: alarm hold length in ticks, legal range 1..255.
REQ-004 SHALL have derived constant CH_W = max(1, clog2(NUM_CH)).
REQ-005 SHALL have port clk, input, 1: single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port tick, input, 1: one-cycle 1 s count-enable pulse.
REQ-008 SHALL have port cmd_valid, input, 1: command request.
REQ-009 SHALL have port cmd_ready, output, 1: command accept.
REQ-010 SHALL have port cmd_op, input, 2: 0 LOAD, 1 START, 2 PAUSE, 3 CLEAR.
REQ-011 SHALL have port cmd_ch, input, CH_W: target channel.
REQ-012 SHALL have port cmd_time, input, 16: BCD {tens_min, min, tens_sec, sec}, with sec in [3:0].
REQ-013 SHALL have port disp_ch, input, CH_W: channel to show.
REQ-014 SHALL have port disp_time, output, 16: BCD time of channel disp_ch.
REQ-015 SHALL have port running, output, NUM_CH: per-channel RUNNING-state flag.
REQ-016 SHALL have port done, output, NUM_CH: one-cycle expiry pulse per channel.
REQ-017 SHALL have port alarm, output, NUM_CH: per-channel alarm level (see Configuration).
REQ-018 SHALL have port cmd_err, output, 1: one-cycle pulse when a command is rejected.

Function
REQ-019 Each channel SHALL hold one of the states IDLE, LOADED, RUNNING, PAUSED, EXPIRED, plus a 16-bit BCD time register.
REQ-020 cmd_ready SHALL equal the inverse of tick; a command is accepted only in a cycle where cmd_valid and cmd_ready are both high, and is applied at the next edge.
REQ-021 A command with cmd_ch >= NUM_CH SHALL be ignored, and cmd_err SHALL pulse.
REQ-022 LOAD SHALL be legal only if every digit is <= 9, tens_sec is <= 5 and tens_min is <= MAX_TENS_MIN.
REQ-023 A legal LOAD in any state SHALL write the time register and enter LOADED; an illegal LOAD SHALL be ignored and cmd_err SHALL pulse.
REQ-024 START from LOADED or PAUSED with a nonzero time SHALL enter RUNNING.
REQ-025 START with time 00:00, or START from IDLE, RUNNING or EXPIRED, SHALL be ignored and cmd_err SHALL pulse.
REQ-026 PAUSE from RUNNING SHALL enter PAUSED; PAUSE in any other state SHALL be a no-op with no error.
REQ-027 CLEAR SHALL set time to 00:00, enter IDLE and drop that channel's alarm, all in the same edge.
REQ-028 On tick, every RUNNING channel SHALL decrement by one second using a BCD borrow chain: sec 0->9 borrows tens_sec; tens_sec 0->5 borrows min; min 0->9 borrows tens_min.
REQ-029 When a decrement yields 00:00, the channel SHALL enter EXPIRED, and done[ch] SHALL be high for exactly that same following cycle.
REQ-030 Tick latency SHALL be one cycle: a tick in cycle t is visible on disp_time, running and done in cycle t+1.
REQ-031 PAUSED, LOADED, IDLE and EXPIRED channels SHALL ignore tick.
REQ-032 disp_time SHALL be a combinational mux of the time registers; a disp_ch out of range SHALL show 16'h0000.
REQ-033 running[ch] SHALL be high exactly while channel ch is in RUNNING.

Reset
REQ-034 While reset is high, all channels SHALL be IDLE with time 00:00, and running, done, alarm and cmd_err SHALL be 0; this takes effect immediately, with no clock edge needed.
REQ-035 Reset asserted during a countdown SHALL abandon it with no done pulse.
REQ-036 After release, the first tick SHALL be ignored by all channels, since all are IDLE.

Configuration
REQ-037 Macro COUNTDOWN_ALARM_EN SHALL select the alarm feature.
REQ-038 With COUNTDOWN_ALARM_EN defined, alarm[ch] SHALL rise with done[ch] and stay high for ALARM_TICKS ticks.
REQ-039 The alarm SHALL then clear by itself, or clear earlier on CLEAR, LOAD or START to that channel; this needs an 8-bit hold counter per channel.
REQ-040 With COUNTDOWN_ALARM_EN undefined, alarm SHALL be tied to 0, no hold counters SHALL exist, and ALARM_TICKS SHALL be unused.

Structure
REQ-041 Package eggtimer_pkg SHALL hold the cmd_op encoding, the channel state encoding, BCD digit limit constants (9, 5) and the 16-bit BCD time type.
REQ-042 Sub-module bcd_mmss_down SHALL be the one-channel BCD decrement and zero-detect, instanced NUM_CH times.

Verification
REQ-043 LOAD ch0 16'h0105, then START, then 65 ticks -> disp_time steps 01:05, 01:04 ... 00:00; done[0] pulses once, on the 65th tick + 1 cycle; ch0 ends EXPIRED.
REQ-044 Borrow chain: LOAD 16'h1000, START, 1 tick -> 09:59; LOAD 16'h0100, START, 1 tick -> 00:59.
REQ-045 Illegal LOADs 16'h0060, 16'h000A and 16'hA000 (with MAX_TENS_MIN=9) -> cmd_err pulses; time is unchanged.
REQ-046 With cmd_valid held high while tick is high -> cmd_ready is 0 and the command takes effect in the next cycle, not lost; PAUSE mid-run, 5 ticks, then START -> time is frozen over the 5 ticks, then resumes.
REQ-047 NUM_CH=4: run ch1 and ch3 concurrently, with reset asserted mid-count -> all outputs drop to 0 asynchronously; no done pulse.
REQ-048 With COUNTDOWN_ALARM_EN and ALARM_TICKS=3: on expiry, alarm[0] is high for 3 ticks and then low; a CLEAR issued during the hold drops alarm the next cycle.

Source files
------------

// File: rtl/eggtimer_pkg.sv
// -----------------------------------------------------------------------------
// eggtimer_pkg
// Shared types and constants for the countdown timer bank:
//   cmd_op_e     - command opcodes carried on cmd_op
//   ch_state_e   - per-channel state encoding (also exported on state_dbg)
//   bcd_time_t   - 16-bit BCD mm:ss time {tens_min, min, tens_sec, sec}
//   BCD_DIGIT_MAX / BCD_TENS_SEC_MAX - digit limits used by load check and
//                  by the borrow chain
//   bcd_load_ok  - legality check for a LOAD value
// -----------------------------------------------------------------------------
package eggtimer_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_START = 2'd1,
    OP_PAUSE = 2'd2,
    OP_CLEAR = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOADED  = 3'd1,
    ST_RUNNING = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_EXPIRED = 3'd4
  } ch_state_e;

  localparam logic [3:0] BCD_DIGIT_MAX    = 4'd9;
  localparam logic [3:0] BCD_TENS_SEC_MAX = 4'd5;

  typedef struct packed {
    logic [3:0] tens_min;
    logic [3:0] min;
    logic [3:0] tens_sec;
    logic [3:0] sec;
  } bcd_time_t;

  localparam bcd_time_t BCD_ZERO = '0;

  // A LOAD value is legal when every digit is decimal, seconds are below 60
  // and the tens-of-minutes digit does not exceed the configured ceiling.
  function automatic logic bcd_load_ok(input bcd_time_t t,
                                       input logic [3:0] max_tens_min);
    return (t.sec      <= BCD_DIGIT_MAX)    &&
           (t.tens_sec <= BCD_TENS_SEC_MAX) &&
           (t.min      <= BCD_DIGIT_MAX)    &&
           (t.tens_min <= BCD_DIGIT_MAX)    &&
           (t.tens_min <= max_tens_min);
  endfunction

endpackage

// File: rtl/bcd_mmss_down.sv
// -----------------------------------------------------------------------------
// bcd_mmss_down
// Combinational one-second decrement of a BCD mm:ss value plus a zero detect
// on the result. One instance per channel.
//   time_i  - current BCD time (never 00:00 while the channel is counting)
//   time_o  - time_i minus one second, BCD borrow chain applied
//   zero_o  - high when time_o is 00:00
// -----------------------------------------------------------------------------
module bcd_mmss_down
  import eggtimer_pkg::*;
(
  input  bcd_time_t time_i,
  output bcd_time_t time_o,
  output logic      zero_o
);

  // Borrow ripples sec -> tens_sec -> min -> tens_min; a digit at zero
  // wraps to its maximum (9, 5, 9) and borrows from the next one up.
  always_comb begin
    time_o = time_i;
    if (time_i.sec != 4'd0) begin
      time_o.sec = time_i.sec - 4'd1;
    end else begin
      time_o.sec = BCD_DIGIT_MAX;
      if (time_i.tens_sec != 4'd0) begin
        time_o.tens_sec = time_i.tens_sec - 4'd1;
      end else begin
        time_o.tens_sec = BCD_TENS_SEC_MAX;
        if (time_i.min != 4'd0) begin
          time_o.min = time_i.min - 4'd1;
        end else begin
          time_o.min      = BCD_DIGIT_MAX;
          time_o.tens_min = time_i.tens_min - 4'd1;
        end
      end
    end
  end

  assign zero_o = (time_o == BCD_ZERO);

endmodule

// File: rtl/countdown_timer_bank.sv
// -----------------------------------------------------------------------------
// countdown_timer_bank
// Bank of NUM_CH independent BCD mm:ss countdown timers sharing one command
// port and one 1 s tick.
//
// Optional feature macro: COUNTDOWN_ALARM_EN
//   defined   - each channel holds an alarm level for ALARM_TICKS ticks after
//               expiry (8-bit hold counter per channel)
//   undefined - alarm is tied low, no hold counters
//
// Ports
//   clk, reset      - rising-edge clock, asynchronous active-high reset
//   tick            - one-cycle 1 s count enable
//   cmd_valid/ready - command handshake; cmd_op/cmd_ch/cmd_time payload
//   disp_ch         - channel selected onto disp_time (out of range -> 0000)
//   running         - per-channel RUNNING flag
//   done            - per-channel one-cycle expiry pulse
//   alarm           - per-channel alarm level
//   cmd_err         - one-cycle pulse for a rejected command
//   state_dbg       - per-channel state, 3 bits per channel (ch0 in [2:0])
//
// Handshake: a command transfers in a cycle where cmd_valid && cmd_ready;
// cmd_ready is simply !tick, so a command offered during a tick is held off
// for one cycle and never conflicts with a countdown step. The accepted
// command takes effect at the following edge.
// -----------------------------------------------------------------------------
module countdown_timer_bank
  import eggtimer_pkg::*;
#(
  parameter  int NUM_CH       = 4,
  parameter  int MAX_TENS_MIN = 9,
  parameter  int ALARM_TICKS  = 10,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [CH_W-1:0]     cmd_ch,
  input  logic [15:0]         cmd_time,
  input  logic [CH_W-1:0]     disp_ch,
  output logic [15:0]         disp_time,
  output logic [NUM_CH-1:0]   running,
  output logic [NUM_CH-1:0]   done,
  output logic [NUM_CH-1:0]   alarm,
  output logic                cmd_err,
  output logic [3*NUM_CH-1:0] state_dbg
);

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("countdown_timer_bank: NUM_CH out of range 1..16");
  end
  if (ALARM_TICKS < 1 || ALARM_TICKS > 255) begin : g_bad_alarm_ticks
    $error("countdown_timer_bank: ALARM_TICKS out of range 1..255");
  end

  localparam logic [CH_W:0] NUM_CH_W = (CH_W + 1)'(NUM_CH);

  ch_state_e         state_q [NUM_CH];
  ch_state_e         state_d [NUM_CH];
  bcd_time_t         time_q  [NUM_CH];
  bcd_time_t         time_d  [NUM_CH];
  bcd_time_t         dec_time[NUM_CH];
  logic [NUM_CH-1:0] dec_zero;
  logic [NUM_CH-1:0] done_q, done_d;
  logic              err_q, err_d;
  logic [NUM_CH-1:0] cmd_hit;
  logic              cmd_acc, cmd_ch_ok, load_ok;
  cmd_op_e           op;
  bcd_time_t         cmd_t;

  assign cmd_ready = ~tick;
  assign cmd_acc   = cmd_valid & ~tick;
  assign cmd_ch_ok = ({1'b0, cmd_ch} < NUM_CH_W);
  assign op        = cmd_op_e'(cmd_op);
  assign cmd_t     = bcd_time_t'(cmd_time);
  assign load_ok   = bcd_load_ok(cmd_t, 4'(MAX_TENS_MIN));

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    bcd_mmss_down u_dec (
      .time_i (time_q[g]),
      .time_o (dec_time[g]),
      .zero_o (dec_zero[g])
    );
    assign running[g]           = (state_q[g] == ST_RUNNING);
    assign state_dbg[3*g +: 3]  = state_q[g];
  end

  // Equality decode never hits a channel that does not exist.
  always_comb begin
    cmd_hit = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      cmd_hit[ch] = cmd_acc && (cmd_ch == CH_W'(ch));
    end
  end

  // Tick and command are mutually exclusive (cmd_ready = !tick), so each
  // channel sees at most one of the two updates per cycle.
  always_comb begin
    err_d = cmd_acc && !cmd_ch_ok;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      state_d[ch] = state_q[ch];
      time_d[ch]  = time_q[ch];
      done_d[ch]  = 1'b0;
      if (tick && state_q[ch] == ST_RUNNING) begin
        time_d[ch] = dec_time[ch];
        if (dec_zero[ch]) begin
          state_d[ch] = ST_EXPIRED;
          done_d[ch]  = 1'b1;
        end
      end
      if (cmd_hit[ch]) begin
        case (op)
          OP_LOAD: begin
            if (load_ok) begin
              time_d[ch]  = cmd_t;
              state_d[ch] = ST_LOADED;
            end else begin
              err_d = 1'b1;
            end
          end
          OP_START: begin
            if ((state_q[ch] == ST_LOADED || state_q[ch] == ST_PAUSED) &&
                time_q[ch] != BCD_ZERO) begin
              state_d[ch] = ST_RUNNING;
            end else begin
              err_d = 1'b1;
            end
          end
          OP_PAUSE: begin
            if (state_q[ch] == ST_RUNNING) state_d[ch] = ST_PAUSED;
          end
          OP_CLEAR: begin
            time_d[ch]  = BCD_ZERO;
            state_d[ch] = ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        state_q[ch] <= ST_IDLE;
        time_q[ch]  <= BCD_ZERO;
      end
      done_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        state_q[ch] <= state_d[ch];
        time_q[ch]  <= time_d[ch];
      end
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign done    = done_q;
  assign cmd_err = err_q;

  always_comb begin
    disp_time = 16'h0000;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (disp_ch == CH_W'(ch)) disp_time = time_q[ch];
    end
  end

`ifdef COUNTDOWN_ALARM_EN
  logic [7:0]        hold_q [NUM_CH];
  logic [NUM_CH-1:0] alarm_q;
  logic [NUM_CH-1:0] alarm_kill;

  // LOAD, START and CLEAR to a channel silence its alarm, legal or not.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      alarm_kill[ch] = cmd_hit[ch] && (op != OP_PAUSE);
    end
  end

  // The expiry tick arms the counter; only later ticks count it down.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm_q <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) hold_q[ch] <= 8'd0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (alarm_kill[ch]) begin
          alarm_q[ch] <= 1'b0;
          hold_q[ch]  <= 8'd0;
        end else if (done_d[ch]) begin
          alarm_q[ch] <= 1'b1;
          hold_q[ch]  <= 8'(ALARM_TICKS);
        end else if (alarm_q[ch] && tick) begin
          hold_q[ch] <= hold_q[ch] - 8'd1;
          if (hold_q[ch] == 8'd1) alarm_q[ch] <= 1'b0;
        end
      end
    end
  end

  assign alarm = alarm_q;
`else
  assign alarm = '0;
`endif

endmodule

// File: tb/tb_countdown_timer_bank.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer_bank
// Directed bench for countdown_timer_bank (NUM_CH=4, ALARM_TICKS=3): a table
// of command/tick vectors with hand-computed results, followed by hand-written
// sequences for handshake back-pressure, asynchronous reset and the alarm.
// -----------------------------------------------------------------------------
module tb_countdown_timer_bank;
  import eggtimer_pkg::*;

  localparam int K_CMD  = 0;
  localparam int K_TICK = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [1:0]  cmd_ch = 2'd0;
  logic [15:0] cmd_time = 16'h0;
  logic [1:0]  disp_ch = 2'd0;
  logic [15:0] disp_time;
  logic [3:0]  running, done, alarm;
  logic        cmd_err;
  logic [11:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  // clock / reset
  always #5 clk = ~clk;

  countdown_timer_bank #(
    .NUM_CH       (4),
    .MAX_TENS_MIN (9),
    .ALARM_TICKS  (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_ch    (cmd_ch),
    .cmd_time  (cmd_time),
    .disp_ch   (disp_ch),
    .disp_time (disp_time),
    .running   (running),
    .done      (done),
    .alarm     (alarm),
    .cmd_err   (cmd_err),
    .state_dbg (state_dbg)
  );

  typedef struct {
    string       name;
    int          kind;
    logic [1:0]  op;
    logic [1:0]  ch;
    logic [15:0] t;
    int          n;
    logic [1:0]  dch;
    logic [15:0] e_time;
    logic [3:0]  e_run;
    logic [3:0]  e_done;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];
  vec_t v;

  // scoreboard compare
  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge,
  // outputs are sampled at that same point
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [1:0] ch,
                        input logic [15:0] t);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_ch    = ch;
    cmd_time  = t;
    step();
    cmd_valid = 1'b0;
  endtask

  function automatic vec_t mk(input string name, input int kind,
                              input logic [1:0] op, input logic [1:0] ch,
                              input logic [15:0] t, input int n,
                              input logic [1:0] dch, input logic [15:0] et,
                              input logic [3:0] er, input logic [3:0] ed,
                              input logic ee);
    vec_t r;
    r.name = name; r.kind = kind; r.op = op; r.ch = ch; r.t = t; r.n = n;
    r.dch = dch; r.e_time = et; r.e_run = er; r.e_done = ed; r.e_err = ee;
    return r;
  endfunction

  initial begin
    // asynchronous reset: outputs must clear before any clock edge
    #1 reset = 1'b1;
    #1;
    check("rst_running", 16'(running), 16'h0);
    check("rst_done",    16'(done),    16'h0);
    check("rst_alarm",   16'(alarm),   16'h0);
    check("rst_err",     16'(cmd_err), 16'h0);
    check("rst_disp",    disp_time,    16'h0000);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    //            name          kind    op        ch    time   n   dch  e_time   run    done   err
    tbl.push_back(mk("first_tick", K_TICK, OP_LOAD,  2'd0, 16'h0, 1,  2'd0, 16'h0000, 4'h0, 4'h0, 1'b0));
    tbl.push_back(mk("load_0105",  K_CMD,  OP_LOAD,  2'd0, 16'h0105, 0, 2'd0, 16'h0105, 4'h0, 4'h0, 1'b0));
    tbl.push_back(mk("start_0105", K_CMD,  OP_START, 2'd0, 16'h0, 0,  2'd0, 16'h0105, 4'h1, 4'h0, 1'b0));
    tbl.push_back(mk("tick_0104",  K_TICK, OP_LOAD,  2'd0, 16'h0, 1,  2'd0, 16'h0104, 4'h1, 4'h0, 1'b0));
    tbl.push_back(mk("tick_0100",  K_TICK, OP_LOAD,  2'd0, 16'h0, 4,  2'd0, 16'h0100, 4'h1, 4'h0, 1'b0));
    tbl.push_back(mk("tick_0059",  K_TICK, OP_LOAD,  2'd0, 16'h0, 1,  2'd0, 16'h0059, 4'h1, 4'h0, 1'b0));
    tbl.push_back(mk("tick_0001",  K_TICK, OP_LOAD,  2'd0, 16'h0, 58, 2'd0, 16'h0001, 4'h1, 4'h0, 1'b0));
    tbl.push_back(mk("tick_exp",   K_TICK, OP_LOAD,  2'd0, 16'h0, 1,  2'd0, 16'h0000, 4'h0, 4'h1, 1'b0));
    tbl.push_back(mk("start_exp",  K_CMD,  OP_START, 2'd0, 16'h0, 0,  2'd0, 16'h0000, 4'h0, 4'h0, 1'b1));
    tbl.push_back(mk("load_1000",  K_CMD,  OP_LOAD,  2'd0, 16'h1000, 0, 2'd0, 16'h1000, 4'h0, 4'h0, 1'b0));
    tbl.push_back(mk("start_1000", K_CMD,  OP_START, 2'd0, 16'h0, 0,  2'd0, 16'h1000, 4'h1, 4'h0, 1'b0));
    tbl.push_back(mk("tick_0959",  K_TICK, OP_LOAD,  2'd0, 16'h0, 1,  2'd0, 16'h0959, 4'h1, 4'h0, 1'b0));
    tbl.push_back(mk("load_0100",  K_CMD,  OP_LOAD,  2'd0, 16'h0100, 0, 2'd0, 16'h0100, 4'h0, 4'h0, 1'b0));
    tbl.push_back(mk("start_0100", K_CMD,  OP_START, 2'd0, 16'h0, 0,  2'd0, 16'h0100, 4'h1, 4'h0, 1'b0));
    tbl.push_back(mk("tick_b0059", K_TICK, OP_LOAD,  2'd0, 16'h0, 1,  2'd0, 16'h0059, 4'h1, 4'h0, 1'b0));
    tbl.push_back(mk("bad_0060",   K_CMD,  OP_LOAD,  2'd0, 16'h0060, 0, 2'd0, 16'h0059, 4'h1, 4'h0, 1'b1));
    tbl.push_back(mk("bad_000A",   K_CMD,  OP_LOAD,  2'd0, 16'h000A, 0, 2'd0, 16'h0059, 4'h1, 4'h0, 1'b1));
    tbl.push_back(mk("bad_A000",   K_CMD,  OP_LOAD,  2'd0, 16'hA000, 0, 2'd0, 16'h0059, 4'h1, 4'h0, 1'b1));
    tbl.push_back(mk("pause",      K_CMD,  OP_PAUSE, 2'd0, 16'h0, 0,  2'd0, 16'h0059, 4'h0, 4'h0, 1'b0));
    tbl.push_back(mk("frozen",     K_TICK, OP_LOAD,  2'd0, 16'h0, 5,  2'd0, 16'h0059, 4'h0, 4'h0, 1'b0));
    tbl.push_back(mk("resume",     K_CMD,  OP_START, 2'd0, 16'h0, 0,  2'd0, 16'h0059, 4'h1, 4'h0, 1'b0));
    tbl.push_back(mk("tick_0058",  K_TICK, OP_LOAD,  2'd0, 16'h0, 1,  2'd0, 16'h0058, 4'h1, 4'h0, 1'b0));
    tbl.push_back(mk("pause2",     K_CMD,  OP_PAUSE, 2'd0, 16'h0, 0,  2'd0, 16'h0058, 4'h0, 4'h0, 1'b0));
    tbl.push_back(mk("pause_noop", K_CMD,  OP_PAUSE, 2'd0, 16'h0, 0,  2'd0, 16'h0058, 4'h0, 4'h0, 1'b0));
    tbl.push_back(mk("clear",      K_CMD,  OP_CLEAR, 2'd0, 16'h0, 0,  2'd0, 16'h0000, 4'h0, 4'h0, 1'b0));
    tbl.push_back(mk("start_idle", K_CMD,  OP_START, 2'd0, 16'h0, 0,  2'd0, 16'h0000, 4'h0, 4'h0, 1'b1));
    tbl.push_back(mk("load_zero",  K_CMD,  OP_LOAD,  2'd0, 16'h0000, 0, 2'd0, 16'h0000, 4'h0, 4'h0, 1'b0));
    tbl.push_back(mk("start_zero", K_CMD,  OP_START, 2'd0, 16'h0, 0,  2'd0, 16'h0000, 4'h0, 4'h0, 1'b1));
    tbl.push_back(mk("load_9959",  K_CMD,  OP_LOAD,  2'd2, 16'h9959, 0, 2'd2, 16'h9959, 4'h0, 4'h0, 1'b0));
    tbl.push_back(mk("start_ch2",  K_CMD,  OP_START, 2'd2, 16'h0, 0,  2'd2, 16'h9959, 4'h4, 4'h0, 1'b0));
    tbl.push_back(mk("tick_9958",  K_TICK, OP_LOAD,  2'd0, 16'h0, 1,  2'd2, 16'h9958, 4'h4, 4'h0, 1'b0));
    tbl.push_back(mk("pause_ch2",  K_CMD,  OP_PAUSE, 2'd2, 16'h0, 0,  2'd2, 16'h9958, 4'h0, 4'h0, 1'b0));
    tbl.push_back(mk("load_0059",  K_CMD,  OP_LOAD,  2'd3, 16'h0059, 0, 2'd3, 16'h0059, 4'h0, 4'h0, 1'b0));
    tbl.push_back(mk("ch1_idle",   K_CMD,  OP_PAUSE, 2'd1, 16'h0, 0,  2'd1, 16'h0000, 4'h0, 4'h0, 1'b0));

    foreach (tbl[i]) begin
      v = tbl[i];
      disp_ch = v.dch;
      if (v.kind == K_CMD) begin
        do_cmd(v.op, v.ch, v.t);
        check({v.name, " done"}, 16'(done), 16'(v.e_done));
      end else begin
        for (int k = 0; k < v.n; k++) begin
          do_tick();
          check({v.name, " done"}, 16'(done),
                (k == v.n - 1) ? 16'(v.e_done) : 16'h0);
        end
      end
      check({v.name, " time"}, disp_time, v.e_time);
      check({v.name, " running"}, 16'(running), 16'(v.e_run));
      check({v.name, " err"}, 16'(cmd_err), 16'(v.e_err));
    end

    // command offered during a tick is held off, then applied
    disp_ch   = 2'd1;
    tick      = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    cmd_ch    = 2'd1;
    cmd_time  = 16'h0030;
    #1;
    check("bp_ready_low", 16'(cmd_ready), 16'h0);
    @(posedge clk);
    #1;
    check("bp_not_yet", disp_time, 16'h0000);
    tick = 1'b0;
    #1;
    check("bp_ready_high", 16'(cmd_ready), 16'h1);
    step();
    cmd_valid = 1'b0;
    check("bp_applied", disp_time, 16'h0030);
    check("bp_err", 16'(cmd_err), 16'h0);

    // two channels counting, reset mid-count
    do_cmd(OP_LOAD, 2'd1, 16'h0003);
    do_cmd(OP_START, 2'd1, 16'h0);
    do_cmd(OP_LOAD, 2'd3, 16'h0002);
    do_cmd(OP_START, 2'd3, 16'h0);
    do_tick();
    check("multi_running", 16'(running), 16'hA);
    check("multi_ch1", disp_time, 16'h0002);
    disp_ch = 2'd3;
    #1;
    check("multi_ch3", disp_time, 16'h0001);
    do_cmd(OP_LOAD, 2'd0, 16'h00AA);
    check("multi_err", 16'(cmd_err), 16'h1);
    reset = 1'b1;
    #1;
    check("arst_running", 16'(running), 16'h0);
    check("arst_err", 16'(cmd_err), 16'h0);
    check("arst_disp", disp_time, 16'h0000);
    check("arst_done", 16'(done), 16'h0);
    check("arst_alarm", 16'(alarm), 16'h0);
    tick = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("arst_no_done", 16'(done), 16'h0);
    end
    tick  = 1'b0;
    reset = 1'b0;
    do_tick();
    check("post_rst_running", 16'(running), 16'h0);
    check("post_rst_disp", disp_time, 16'h0000);
    check("post_rst_done", 16'(done), 16'h0);

    // expiry, done width, EXPIRED state and alarm hold
    disp_ch = 2'd0;
    do_cmd(OP_LOAD, 2'd0, 16'h0002);
    do_cmd(OP_START, 2'd0, 16'h0);
    do_tick();
    check("al_0001", disp_time, 16'h0001);
    check("al_pre_alarm", 16'(alarm), 16'h0);
    do_tick();
    check("al_done", 16'(done), 16'h1);
    step();
    check("al_done_once", 16'(done), 16'h0);
    check("al_expired", 16'(state_dbg[2:0]), 16'(ST_EXPIRED));
`ifdef COUNTDOWN_ALARM_EN
    check("al_rise", 16'(alarm), 16'h1);
    do_tick();
    check("al_hold1", 16'(alarm), 16'h1);
    do_tick();
    check("al_hold2", 16'(alarm), 16'h1);
    do_tick();
    check("al_drop", 16'(alarm), 16'h0);
`else
    check("al_off", 16'(alarm), 16'h0);
`endif
    do_cmd(OP_LOAD, 2'd0, 16'h0001);
    do_cmd(OP_START, 2'd0, 16'h0);
    do_tick();
    check("al2_done", 16'(done), 16'h1);
`ifdef COUNTDOWN_ALARM_EN
    check("al2_rise", 16'(alarm), 16'h1);
`else
    check("al2_off", 16'(alarm), 16'h0);
`endif
    do_cmd(OP_CLEAR, 2'd0, 16'h0);
    check("al2_clear_alarm", 16'(alarm), 16'h0);
    check("al2_clear_time", disp_time, 16'h0000);
    check("al2_clear_idle", 16'(state_dbg[2:0]), 16'(ST_IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
